// File: rtl/frame_strobe_sequencer.sv
// Column frame loader: per word drives FrameData, waits SetupCycles, then pulses one FrameStrobe bit.
// Optional running word checksum is enabled with `define FRAME_SEQ_CHECKSUM_EN.
module frame_strobe_sequencer #(
   parameter int MaxFramesPerCol = 20,
   parameter int FrameBitsPerRow = 32,
   parameter int SetupCycles     = 1,
   parameter int StrobeCycles    = 1,
   localparam int AW             = $clog2(MaxFramesPerCol + 1)
) (
   input  logic                       CLK,
   input  logic                       RESET,
   input  logic                       start,
   input  logic [AW-1:0]              start_frame,
   input  logic [AW-1:0]              frame_count,
   input  logic                       abort,
   input  logic [FrameBitsPerRow-1:0] word_data,
   input  logic                       word_valid,
   output logic                       word_ready,
   output logic [FrameBitsPerRow-1:0] FrameData,
   output logic [MaxFramesPerCol-1:0] FrameStrobe,
   output logic                       busy,
   output logic                       done,
   output logic                       err,
   output logic [31:0]                checksum
);

   localparam int CMAX = (SetupCycles > StrobeCycles) ? SetupCycles : StrobeCycles;
   localparam int CW   = $clog2(CMAX + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_SETUP, S_STROBE, S_HOLD, S_DONE
   } state_t;

   state_t                     state_q, state_d;
   logic [AW-1:0]              idx_q, idx_d;
   logic [AW-1:0]              rem_q, rem_d;
   logic [CW-1:0]              cnt_q, cnt_d;
   logic [FrameBitsPerRow-1:0] data_q, data_d;
   logic [MaxFramesPerCol-1:0] strobe_q, strobe_d;
   logic                       ready_q, ready_d;
   logic                       busy_q, busy_d;
   logic                       done_q, done_d;
   logic                       err_q, err_d;
   logic [AW:0]                range_end;
   logic                       reject;

   // Range end compared one bit wider so start_frame+frame_count cannot wrap.
   assign range_end = {1'b0, start_frame} + {1'b0, frame_count};
   assign reject    = (frame_count == '0) || (range_end > (AW+1)'(MaxFramesPerCol));

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      err_d   = 1'b0;
      if (abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  if (reject) begin
                     err_d = 1'b1;
                  end else begin
                     idx_d   = start_frame;
                     rem_d   = frame_count;
                     state_d = S_LOAD;
                  end
               end
            end
            S_LOAD: begin
               if (word_valid) begin
                  data_d  = word_data;
                  cnt_d   = CW'(SetupCycles - 1);
                  state_d = S_SETUP;
               end
            end
            S_SETUP: begin
               if (cnt_q == '0) begin
                  cnt_d   = CW'(StrobeCycles - 1);
                  state_d = S_STROBE;
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
            S_STROBE: begin
               if (cnt_q == '0) state_d = S_HOLD;
               else             cnt_d   = cnt_q - CW'(1);
            end
            S_HOLD: begin
               if (rem_q == AW'(1)) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + AW'(1);
                  rem_d   = rem_q - AW'(1);
                  state_d = S_LOAD;
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end

      // Outputs are registered from the next state so they line up with it.
      ready_d = (state_d == S_LOAD);
      busy_d  = (state_d != S_IDLE);
      done_d  = (state_q == S_DONE) && !abort;
      for (int i = 0; i < MaxFramesPerCol; i++)
         strobe_d[i] = (state_d == S_STROBE) && (idx_d == AW'(i));
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         rem_q    <= '0;
         cnt_q    <= '0;
         data_q   <= '0;
         strobe_q <= '0;
         ready_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         rem_q    <= rem_d;
         cnt_q    <= cnt_d;
         data_q   <= data_d;
         strobe_q <= strobe_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign word_ready  = ready_q;
   assign FrameData   = data_q;
   assign FrameStrobe = strobe_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;

`ifdef FRAME_SEQ_CHECKSUM_EN
   logic [31:0] checksum_q, checksum_d;
   logic        cks_clr, cks_add;

   // Abort beats both a start and a word handshake, so neither touches the sum.
   assign cks_clr = !abort && (state_q == S_IDLE) && start && !reject;
   assign cks_add = !abort && (state_q == S_LOAD) && word_valid;

   always_comb begin
      checksum_d = checksum_q;
      if (cks_clr)      checksum_d = '0;
      else if (cks_add) checksum_d = checksum_q + 32'(word_data);
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) checksum_q <= '0;
      else       checksum_q <= checksum_d;
   end

   assign checksum = checksum_q;
`else
   assign checksum = '0;
`endif

endmodule

// File: doc/frame_strobe_sequencer.md
Name: frame_strobe_sequencer

Overview:
Loads configuration frames into one tile column's frame latches. It accepts a frame-range command and a valid/ready word stream. For each word it drives FrameData, waits a setup interval, then pulses exactly one FrameStrobe bit. It sits between the fabric config word source and the column FrameData/FrameStrobe buses that feed the per-tile ConfigMem latches.

Parameters:
MaxFramesPerCol, 20, number of FrameStrobe lines (frames per column)
FrameBitsPerRow, 32, FrameData width and word width
SetupCycles, 1, cycles FrameData is stable before strobe rises (>=1)
StrobeCycles, 1, cycles FrameStrobe bit stays high (>=1)

Ports:
CLK  input  1  clock
RESET  input  1  asynchronous active-high reset
start  input  1  begin a load; sampled only in IDLE
start_frame  input  AW  first frame index; AW = ceil(log2(MaxFramesPerCol+1))
frame_count  input  AW  number of consecutive frames to load
abort  input  1  synchronous abort, any state
word_data  input  FrameBitsPerRow  frame word
word_valid  input  1  word_data valid
word_ready  output  1  sequencer accepts word this cycle
FrameData  output  FrameBitsPerRow  registered frame data bus
FrameStrobe  output  MaxFramesPerCol  registered one-hot (or zero) strobe
busy  output  1  high in any state except IDLE
done  output  1  1-cycle pulse after the last frame's HOLD
err  output  1  1-cycle pulse on a rejected start
checksum  output  32  running word checksum (optional feature)

Behaviour:
- Reset (async, RESET=1) values: state=IDLE; FrameData=0; FrameStrobe=0; word_ready=0; busy=0; done=0; err=0; checksum=0; idx=0; remaining=0.
- All outputs are registered. word_ready is 1 exactly when state=LOAD.
- IDLE, start=1:
  - Reject if frame_count==0 or start_frame+frame_count > MaxFramesPerCol (compare at AW+1 bits). On reject: err=1 for one cycle, stay IDLE.
  - Otherwise: idx<=start_frame, remaining<=frame_count, go LOAD.
- LOAD: word_ready=1; wait indefinitely. On word_valid&&word_ready at edge k: FrameData<=word_data, go SETUP.
- SETUP: FrameStrobe=0 for SetupCycles cycles; FrameData held.
- STROBE: FrameStrobe[idx]=1, all other bits 0, for StrobeCycles cycles; FrameData held.
- HOLD: one cycle, FrameStrobe=0, FrameData held. Then:
  - If remaining==1: go DONE.
  - Else: idx<=idx+1, remaining<=remaining-1, go LOAD.
- DONE: done=1 for one cycle, then go IDLE.
- Timing: FrameStrobe rises at edge k+SetupCycles and falls at edge k+SetupCycles+StrobeCycles. Minimum per-frame period is 1+SetupCycles+StrobeCycles+1 cycles (4 at defaults).
- FrameData keeps its last value after DONE/IDLE and is never cleared except by RESET. The latches hold once E drops.
- At most one FrameStrobe bit is high in any cycle. FrameData never changes while any strobe bit is high.
- abort=1, any state: at the next edge FrameStrobe=0, state=IDLE, done=0, no err. FrameData is held. abort has priority over start and over a word handshake in the same cycle.
- start while busy is ignored.
- RESET mid-STROBE clears FrameStrobe asynchronously. A partially loaded frame range is the host's responsibility.
- idx never exceeds MaxFramesPerCol-1; the start check guarantees this.

Optional Feature:
FRAME_SEQ_CHECKSUM_EN
- Defined: checksum<=checksum+word_data (mod 2^32, word zero-extended to 32 bits) on every accepted word. checksum clears to 0 on an accepted (non-rejected) start and on RESET. It is not cleared by abort or DONE.
- Undefined: checksum is tied to 0, and no adder or register is synthesised.

Test Plan:
- Reset, then start, start_frame=0, frame_count=1, word 0xDEADBEEF valid immediately -> FrameData=0xDEADBEEF at handshake+1. FrameStrobe=0x00001 exactly at edges k+1..k+2. done pulses 2 cycles after strobe falls; busy drops with done.
- start_frame=17, frame_count=3, words 0x1,0x2,0x3 back-to-back -> strobes bit17, bit18, bit19 in order, each 1 cycle. Frame period 4 cycles. Never two bits high.
- start_frame=18, frame_count=3 -> err=1 for one cycle, busy stays 0, FrameStrobe stays 0. The same test with frame_count=0 -> err.
- word_valid stalled 10 cycles in LOAD -> word_ready stays 1, FrameStrobe=0, FrameData unchanged. Load resumes normally when valid rises.
- abort asserted during STROBE of frame 5 -> FrameStrobe=0 next edge, state IDLE, no done. A new start is then accepted.
- With FRAME_SEQ_CHECKSUM_EN, 4 words 0xFFFFFFFF -> checksum=0xFFFFFFFC. Without the macro -> checksum=0.
